// File: rtl/dsp_mac_sequencer.sv
// Sequences signed 18x18 operand beats into one DSP48A1 MAC slice and returns bias + sum(a*b) per vector.
// Result valid AB_STAGES+P_STAGES+1 cycles after the last beat; in_ready low while draining or holding a result.
module dsp_mac_sequencer #(
  parameter int AB_STAGES  = 2,
  parameter int CTL_STAGES = 1,
  parameter int P_STAGES   = 1,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic [47:0]      in_c,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_p,
  output logic [LEN_W-1:0] out_len,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [47:0]      dsp_c,
  output logic [17:0]      dsp_d,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  localparam int DLY       = AB_STAGES - CTL_STAGES;
  localparam int DRAIN_CNT = AB_STAGES + P_STAGES;
  localparam int CNT_W     = (DRAIN_CNT < 2) ? 1 : $clog2(DRAIN_CNT + 1);

  localparam logic [7:0] OP_FIRST = 8'h0D;
  localparam logic [7:0] OP_ACC   = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [47:0]        out_p_q, out_p_d;
  logic [LEN_W-1:0]   out_len_q, out_len_d;
  logic [17:0]        a_q, a_d;
  logic [17:0]        b_q, b_d;
  logic [7:0]         iss_op_q, iss_op_d;
  logic [47:0]        iss_c_q, iss_c_d;
  logic               dsp_rst_q;
  logic               beat;

  // dsp_rst_q doubles as "still in reset": the port stays closed for the cycle the slice is being cleared.
  assign in_ready  = !dsp_rst_q && ((state_q == IDLE) || (state_q == ACCUM));
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == OUT);
  assign out_p     = out_p_q;
  assign out_len   = out_len_q;
  assign dsp_a     = a_q;
  assign dsp_b     = b_q;
  assign dsp_d     = 18'd0;
  assign dsp_rst   = dsp_rst_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    out_p_d   = out_p_q;
    out_len_d = out_len_q;
    a_d       = 18'd0;
    b_d       = 18'd0;
    iss_op_d  = OP_HOLD;
    iss_c_d   = 48'd0;

    case (state_q)
      IDLE: begin
        if (beat) begin
          a_d      = in_a;
          b_d      = in_b;
          iss_op_d = OP_FIRST;
          iss_c_d  = in_c;
          len_d    = LEN_W'(1);
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CNT);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          a_d      = in_a;
          b_d      = in_b;
          iss_op_d = OP_ACC;
          len_d    = (&len_q) ? len_q : len_q + LEN_W'(1);
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CNT);
          end
        end
      end
      DRAIN: begin
        // Last product has reached P once the counter runs out.
        if (cnt_q == '0) begin
          out_p_d   = dsp_p;
          out_len_d = len_q;
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    dsp_rst_q <= !rst_n;
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      out_p_q   <= '0;
      out_len_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      iss_op_q  <= 8'h00;
      iss_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      out_p_q   <= out_p_d;
      out_len_q <= out_len_d;
      a_q       <= a_d;
      b_q       <= b_d;
      iss_op_q  <= iss_op_d;
      iss_c_q   <= iss_c_d;
    end
  end

  // OPMODE/C wait out the extra A/B register depth so they meet M at the post-adder.
  if (DLY == 0) begin : g_no_dly
    assign dsp_opmode = iss_op_q;
    assign dsp_c      = iss_c_q;
  end else begin : g_dly
    logic [7:0]  op_dl_q [DLY];
    logic [47:0] c_dl_q  [DLY];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DLY; i++) begin
          op_dl_q[i] <= 8'h00;
          c_dl_q[i]  <= '0;
        end
      end else begin
        op_dl_q[0] <= iss_op_q;
        c_dl_q[0]  <= iss_c_q;
        for (int i = 1; i < DLY; i++) begin
          op_dl_q[i] <= op_dl_q[i-1];
          c_dl_q[i]  <= c_dl_q[i-1];
        end
      end
    end

    assign dsp_opmode = op_dl_q[DLY-1];
    assign dsp_c      = c_dl_q[DLY-1];
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a DSP48A1-style slice model closes the loop and a
// reference model (bias + sum of products per vector) is compared every cycle.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [47:0]      in_c = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [47:0]      out_p;
  logic [LEN_W-1:0] out_len;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [47:0]      dsp_c;
  logic [17:0]      dsp_d;
  logic [7:0]       dsp_opmode;
  logic             dsp_rst;
  logic [47:0]      dsp_p;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .AB_STAGES(2), .CTL_STAGES(1), .P_STAGES(1), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_len(out_len),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
    .dsp_opmode(dsp_opmode), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  // Slice model: A1REG + MREG, CREG/OPMODEREG, PREG; X from OPMODE[1:0], Z from OPMODE[3:2].
  logic [17:0]        s_a1, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_op;
  logic [47:0]        s_c, s_p, s_x, s_z;

  always_comb begin
    s_x = (s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    case (s_op[3:2])
      2'b11:   s_z = s_c;
      2'b10:   s_z = s_p;
      default: s_z = 48'd0;
    endcase
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_op <= '0; s_c <= '0; s_p <= '0;
    end else begin
      s_a1 <= dsp_a;
      s_b1 <= dsp_b;
      s_m  <= $signed(s_a1) * $signed(s_b1);
      s_op <= dsp_opmode;
      s_c  <= dsp_c;
      s_p  <= s_z + s_x;
    end
  end
  assign dsp_p = s_p;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [47:0]      p;
    logic [LEN_W-1:0] len;
  } res_t;

  res_t               exp_q[$];
  logic [47:0]        m_acc = '0;
  int                 m_len = 0;
  bit                 m_invec = 0;
  bit                 m_busy = 0;
  int                 m_hs_edge = 0;
  int                 cyc = 0;
  bit                 mon_en = 0;
  logic               rst_prev = 1'b0;
  bit                 ab_vld = 0;
  logic [17:0]        ab_a, ab_b;
  bit                 op_vld[2] = '{0, 0};
  logic [7:0]         op_code[2];
  logic [47:0]        op_c[2];
  logic               mon_hs;
  logic signed [35:0] mon_prod;
  logic [47:0]        mon_ext;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_n;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", 64'(in_ready), 64'(rst_prev && !m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_busy && (cyc >= m_hs_edge + 4)));
      chk("dsp_rst", 64'(dsp_rst), 64'(!rst_prev));
      chk("dsp_d", 64'(dsp_d), 64'(0));
      if (out_valid && exp_q.size() > 0) begin
        chk("model_out_p", 64'(out_p), 64'(exp_q[0].p));
        chk("model_out_len", 64'(out_len), 64'(exp_q[0].len));
      end
      if (ab_vld) begin
        chk("model_dsp_a", 64'(dsp_a), 64'(ab_a));
        chk("model_dsp_b", 64'(dsp_b), 64'(ab_b));
      end
      if (op_vld[1]) begin
        chk("model_dsp_opmode", 64'(dsp_opmode), 64'(op_code[1]));
        chk("model_dsp_c", 64'(dsp_c), 64'(op_c[1]));
      end

      mon_hs     = rst_n && in_valid && in_ready;
      ab_vld     = 1;
      ab_a       = mon_hs ? in_a : 18'd0;
      ab_b       = mon_hs ? in_b : 18'd0;
      op_vld[1]  = op_vld[0];
      op_code[1] = op_code[0];
      op_c[1]    = op_c[0];
      op_vld[0]  = 0;

      if (!rst_n) begin
        op_vld[1] = 0;
        m_busy    = 0;
        m_invec   = 0;
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && m_busy && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          m_busy = 0;
        end
        if (mon_hs) begin
          mon_prod   = $signed(in_a) * $signed(in_b);
          mon_ext    = {{12{mon_prod[35]}}, mon_prod};
          op_vld[0]  = 1;
          op_code[0] = m_invec ? 8'h09 : 8'h0D;
          op_c[0]    = m_invec ? 48'd0 : in_c;
          if (!m_invec) begin
            m_acc = in_c + mon_ext;
            m_len = 1;
          end else begin
            m_acc = m_acc + mon_ext;
            if (m_len < (1 << LEN_W) - 1) m_len++;
          end
          if (in_last) begin
            exp_q.push_back('{m_acc, LEN_W'(m_len)});
            m_busy    = 1;
            m_hs_edge = cyc + 1;
            m_invec   = 0;
          end else begin
            m_invec = 1;
          end
        end else if (m_invec) begin
          op_vld[0]  = 1;
          op_code[0] = 8'h08;
          op_c[0]    = 48'd0;
        end
      end
    end
  end

  // Stimulus helpers
  task automatic send(input logic signed [17:0] a, input logic signed [17:0] b,
                      input logic [47:0] c, input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_last = 1'b0;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_result(input string nm, input logic [47:0] p, input int len,
                             input int lat, input int hold);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'(1));
    if (lat >= 0) chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_p"}, 64'(out_p), 64'(p));
    chk({nm, "_len"}, 64'(out_len), 64'(len));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 64'(out_valid), 64'(1));
      chk({nm, "_hold_p"}, 64'(out_p), 64'(p));
      chk({nm, "_hold_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_released_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_released_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_out_p"}, 64'(out_p), 64'(0));
    chk({nm, "_out_len"}, 64'(out_len), 64'(0));
    chk({nm, "_dsp_a"}, 64'(dsp_a), 64'(0));
    chk({nm, "_dsp_b"}, 64'(dsp_b), 64'(0));
    chk({nm, "_dsp_c"}, 64'(dsp_c), 64'(0));
    chk({nm, "_dsp_opmode"}, 64'(dsp_opmode), 64'(0));
    chk({nm, "_dsp_rst"}, 64'(dsp_rst), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("por_ready_after_release", 64'(in_ready), 64'(1));
    chk("por_dsp_rst_low", 64'(dsp_rst), 64'(0));

    // Two beats with bias
    send(18'sd3, 18'sd4, 48'd10, 1'b0);
    send(18'sd5, 18'sd6, 48'd0, 1'b1);
    wait_result("two_beat", 48'd52, 2, 4, 0);

    // Single negative beat
    send(-18'sd2, 18'sd7, 48'd0, 1'b1);
    wait_result("single_neg", 48'hFFFF_FFFF_FFF2, 1, 4, 0);

    // Bubbles between beats issue HOLD
    send(18'sd1, 18'sd1, 48'd0, 1'b0);
    bubble(2);
    chk("bubble_opmode", 64'(dsp_opmode), 64'(8'h08));
    send(18'sd1, 18'sd1, 48'd0, 1'b0);
    bubble(2);
    chk("bubble_opmode2", 64'(dsp_opmode), 64'(8'h08));
    send(18'sd1, 18'sd1, 48'd0, 1'b1);
    wait_result("bubbles", 48'd3, 3, 4, 0);

    // Consumer stalls for 5 cycles
    send(18'sd2, 18'sd3, 48'd5, 1'b1);
    wait_result("stall", 48'd11, 1, 4, 5);

    // Reset mid-vector, then a fresh single-beat vector
    send(18'sd1, 18'sd1, 48'd7, 1'b0);
    send(18'sd2, 18'sd3, 48'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after_release", 64'(in_ready), 64'(1));
    send(18'sd2, 18'sd2, 48'd1, 1'b1);
    wait_result("after_reset", 48'd5, 1, 4, 0);

    // Largest positive operands
    send(18'sd131071, 18'sd131071, 48'd0, 1'b0);
    send(18'sd131071, 18'sd131071, 48'd0, 1'b1);
    wait_result("max_pos", 48'd34359214082, 2, 4, 0);

    // Back-to-back vectors with an always-ready consumer
    out_ready = 1'b1;
    send(18'sd1, -18'sd1, 48'd100, 1'b0);
    send(-18'sd3, -18'sd3, 48'd0, 1'b1);
    send(18'sd7, 18'sd8, -48'sd5, 1'b1);
    send(-18'sd131072, -18'sd131072, 48'd0, 1'b0);
    send(-18'sd131072, 18'sd131071, 48'd0, 1'b1);
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drained", 64'(exp_q.size()), 64'(0));
    chk("b2b_last_p", 64'(out_p), 64'(48'd131072));
    out_ready = 1'b0;
    bubble(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
